picorv32_pcpi_issue: RTL and testbench
======================================

// Module: picorv32_pcpi_issue
// PURPOSE
//  Initiator (CPU) side of the PCPI coprocessor interface. Takes one decoded instruction
//  plus operands from the core over a valid/ready port and drives pcpi_valid/insn/rs1/rs2.
//  Waits for a responder (e.g. the pipelined multiplier) to raise pcpi_ready, then returns
//  pcpi_wr/pcpi_rd to writeback. Traps when no responder claims the instruction in time.
// PARAMETERS
//  TIMEOUT_CYCLES  16  ISSUE cycles without pcpi_wait/pcpi_ready before trap (>=2)
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)  timeout counter width (localparam)
// PORTS
//  clk         in   1   clock; all state on posedge
//  resetn      in   1   reset, asynchronous, active-low
//  req_valid   in   1   core offers an instruction
//  req_ready   out  1   block accepts request (high only in IDLE)
//  req_insn    in   32  instruction word
//  req_rs1     in   32  operand 1
//  req_rs2     in   32  operand 2
//  pcpi_valid  out  1   PCPI request active
//  pcpi_insn   out  32  registered copy of req_insn
//  pcpi_rs1    out  32  registered copy of req_rs1
//  pcpi_rs2    out  32  registered copy of req_rs2
//  pcpi_wr     in   1   responder writes rd (qualified by pcpi_ready)
//  pcpi_rd     in   32  responder result (qualified by pcpi_ready)
//  pcpi_wait   in   1   responder claimed insn, still busy
//  pcpi_ready  in   1   responder done, result valid this cycle
//  rsp_valid   out  1   result/trap available to core
//  rsp_ready   in   1   core consumes response
//  rsp_wr      out  1   write rd
//  rsp_rd      out  32  result data
//  rsp_trap    out  1   illegal instruction (timeout)
// BEHAVIOUR
//  - Reset (resetn low, async): state=IDLE; pcpi_valid, rsp_valid, rsp_wr, rsp_trap = 0;
//    pcpi_insn/rs1/rs2, rsp_rd = 0; counter = 0. Effective immediately, even mid-ISSUE.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE. req_ready = (state==IDLE), combinational.
//  - IDLE: req_valid && req_ready -> capture insn/rs1/rs2, pcpi_valid=1 next cycle, ISSUE.
//  - ISSUE: pcpi_insn/rs1/rs2 stable. Counter +1 per cycle with pcpi_wait=0 && pcpi_ready=0;
//    cleared whenever pcpi_wait=1 (a claimed insn never times out).
//    pcpi_ready=1 -> rsp_wr<=pcpi_wr, rsp_rd<=pcpi_wr?pcpi_rd:0, rsp_trap<=0,
//    pcpi_valid<=0, rsp_valid<=1, -> RESP. pcpi_valid drops the cycle after ready.
//  - Timeout: counter reaches TIMEOUT_CYCLES -> rsp_trap<=1, rsp_wr<=0, rsp_rd<=0,
//    pcpi_valid<=0, rsp_valid<=1, -> RESP. pcpi_ready in the same cycle wins (no trap).
//  - RESP: rsp_* held stable while rsp_valid && !rsp_ready; on rsp_ready -> rsp_valid<=0,
//    IDLE. New request accepted no earlier than the cycle after rsp handshake.
//  - Latency: req accept @T -> pcpi_valid @T+1; pcpi_ready @R -> rsp_valid @R+1.
//  - pcpi_wait/pcpi_ready ignored outside ISSUE. Counter saturates, never wraps.
// CONFIGURATION
//  PICORV32_PCPI_TIMEOUT_EN defined: timeout counter and trap path as above.
//  Not defined: no counter; ISSUE waits indefinitely for pcpi_ready; rsp_trap tied 0.
// TESTING
//  1 MUL insn 0x02B50533, rs1=7, rs2=6, stub raises ready 2 cyc later wr=1 rd=42
//    -> pcpi_valid 1 @T+1..R, rsp_valid @R+1, rsp_rd=0x0000002A, rsp_trap=0.
//  2 (TIMEOUT_EN) insn 0x00000033, no wait/ready -> rsp_trap=1, rsp_rd=0,
//    rsp_valid exactly 16 cycles after pcpi_valid rises.
//  3 (TIMEOUT_EN) pcpi_wait held 40 cyc, then ready wr=1 rd=0xDEADBEEF
//    -> no trap, rsp_rd=0xDEADBEEF.
//  4 Ready coincident with timeout cycle 16, rd=0x5 -> rsp_trap=0, rsp_rd=0x5.
//  5 rsp_ready held low 5 cyc -> rsp_* stable, req_ready=0 until handshake +1 cycle.
//  6 resetn low mid-ISSUE -> pcpi_valid=0 same cycle (async); after release req_ready=1.

Source files
------------

// File: rtl/picorv32_pcpi_issue_if.sv
// Purpose: bundles the core request port, the PCPI bus and the core response
//          port of the PCPI issue block.
// Modports:
//   master - the issue block: accepts req_*, drives pcpi_valid/insn/rs1/rs2,
//            samples pcpi_wr/rd/wait/ready, returns rsp_*.
//   slave  - the surroundings (core + responder), the mirror image of master.
interface picorv32_pcpi_issue_if;
  localparam int unsigned XLEN = 32;

  // core -> issue request
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_insn;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;

  // PCPI bus towards the responder
  logic            pcpi_valid;
  logic [XLEN-1:0] pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  // issue -> core response
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_wr;
  logic [XLEN-1:0] rsp_rd;
  logic            rsp_trap;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  rsp_ready,
    output req_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output rsp_valid, rsp_wr, rsp_rd, rsp_trap
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output rsp_ready,
    input  req_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  rsp_valid, rsp_wr, rsp_rd, rsp_trap
  );
endinterface

// File: rtl/picorv32_pcpi_issue.sv
// Purpose: CPU-side initiator of the PCPI coprocessor interface. Accepts one
//          instruction plus operands, presents it on PCPI until a responder
//          answers with pcpi_ready, then hands pcpi_wr/pcpi_rd back to the core.
// Ports:
//   clk    - clock, all state on posedge
//   resetn - asynchronous active-low reset
//   bus    - picorv32_pcpi_issue_if.master (req_*, pcpi_*, rsp_*)
// Configuration:
//   PICORV32_PCPI_TIMEOUT_EN - when defined, an unclaimed instruction traps after
//   TIMEOUT_CYCLES issue cycles with neither pcpi_wait nor pcpi_ready (TIMEOUT_CYCLES
//   must be >= 2). When undefined, ISSUE waits forever and rsp_trap is tied low.
module picorv32_pcpi_issue
`ifdef PICORV32_PCPI_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input logic                   clk,
  input logic                   resetn,
  picorv32_pcpi_issue_if.master bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pcpi_valid_q, pcpi_valid_d;
  logic [XLEN-1:0]   pcpi_insn_q, pcpi_insn_d;
  logic [XLEN-1:0]   pcpi_rs1_q, pcpi_rs1_d;
  logic [XLEN-1:0]   pcpi_rs2_q, pcpi_rs2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic [XLEN-1:0]   rsp_rd_q, rsp_rd_d;

`ifdef PICORV32_PCPI_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              rsp_trap_q, rsp_trap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pcpi_valid_q <= 1'b0;
      pcpi_insn_q  <= '0;
      pcpi_rs1_q   <= '0;
      pcpi_rs2_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_wr_q     <= 1'b0;
      rsp_rd_q     <= '0;
`ifdef PICORV32_PCPI_TIMEOUT_EN
      rsp_trap_q   <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pcpi_valid_q <= pcpi_valid_d;
      pcpi_insn_q  <= pcpi_insn_d;
      pcpi_rs1_q   <= pcpi_rs1_d;
      pcpi_rs2_q   <= pcpi_rs2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_rd_q     <= rsp_rd_d;
`ifdef PICORV32_PCPI_TIMEOUT_EN
      rsp_trap_q   <= rsp_trap_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    pcpi_valid_d = pcpi_valid_q;
    pcpi_insn_d  = pcpi_insn_q;
    pcpi_rs1_d   = pcpi_rs1_q;
    pcpi_rs2_d   = pcpi_rs2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_rd_d     = rsp_rd_q;
`ifdef PICORV32_PCPI_TIMEOUT_EN
    rsp_trap_d   = rsp_trap_q;
    cnt_d        = cnt_q;
    // Saturating increment; the FSM leaves ISSUE on reaching the limit anyway
    cnt_inc      = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          pcpi_insn_d  = bus.req_insn;
          pcpi_rs1_d   = bus.req_rs1;
          pcpi_rs2_d   = bus.req_rs2;
          pcpi_valid_d = 1'b1;
          state_d      = ISSUE;
`ifdef PICORV32_PCPI_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end

      ISSUE: begin
        // pcpi_ready is tested first so a completion on the timeout cycle wins
        if (bus.pcpi_ready) begin
          rsp_wr_d     = bus.pcpi_wr;
          rsp_rd_d     = bus.pcpi_wr ? bus.pcpi_rd : '0;
          pcpi_valid_d = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
`ifdef PICORV32_PCPI_TIMEOUT_EN
          rsp_trap_d   = 1'b0;
        end else if (bus.pcpi_wait) begin
          // A claimed instruction never times out
          cnt_d        = '0;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_trap_d   = 1'b1;
          rsp_wr_d     = 1'b0;
          rsp_rd_d     = '0;
          pcpi_valid_d = 1'b0;
          rsp_valid_d  = 1'b1;
          cnt_d        = cnt_inc;
          state_d      = RESP;
        end else begin
          cnt_d        = cnt_inc;
`endif
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.pcpi_valid = pcpi_valid_q;
  assign bus.pcpi_insn  = pcpi_insn_q;
  assign bus.pcpi_rs1   = pcpi_rs1_q;
  assign bus.pcpi_rs2   = pcpi_rs2_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_wr     = rsp_wr_q;
  assign bus.rsp_rd     = rsp_rd_q;
`ifdef PICORV32_PCPI_TIMEOUT_EN
  assign bus.rsp_trap   = rsp_trap_q;
`else
  assign bus.rsp_trap   = 1'b0;
`endif

endmodule

// File: tb/tb_picorv32_pcpi_issue.sv
// Bench for picorv32_pcpi_issue. Each transaction is described by a per-cycle
// responder script (pcpi_wait / pcpi_ready / pcpi_wr / pcpi_rd for every ISSUE
// cycle); a reference model walks the script with the protocol rules to decide
// in which cycle the transaction completes and with what response.
module tb_picorv32_pcpi_issue;

  localparam int TO   = 16;
  localparam int MAXP = 128;
`ifdef PICORV32_PCPI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  // Responder script, indexed by ISSUE cycle (0 = first cycle pcpi_valid is high)
  bit          pat_wait  [MAXP];
  bit          pat_ready [MAXP];
  bit          pat_wr    [MAXP];
  logic [31:0] pat_rd    [MAXP];

  picorv32_pcpi_issue_if bus ();

  picorv32_pcpi_issue dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fresh script: no wait/ready, random data noise everywhere
  task automatic clear_pat();
    for (int i = 0; i < MAXP; i++) begin
      pat_wait[i]  = 1'b0;
      pat_ready[i] = 1'b0;
      pat_wr[i]    = 1'($urandom_range(1, 0));
      pat_rd[i]    = $urandom;
    end
  endtask

  // Reference: completion cycle index and whether it is a trap (-1 if never)
  function automatic void model_txn(output int end_idx, output bit trap);
    int idle_run;
    idle_run = 0;
    end_idx  = -1;
    trap     = 1'b0;
    for (int i = 0; i < MAXP; i++) begin
      if (pat_ready[i]) begin
        end_idx = i;
        return;
      end
      idle_run = pat_wait[i] ? 0 : idle_run + 1;
      if (TO_EN && idle_run >= TO) begin
        end_idx = i;
        trap    = 1'b1;
        return;
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_insn   = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = '0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.rsp_ready  = 1'b0;
  endtask

  // One complete transaction; entered and left just after a negedge, DUT in IDLE
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int rsp_delay, input string name);
    int          e;
    bit          trap;
    logic        exp_wr;
    logic [31:0] exp_rd;
    logic [98:0] igot, iexp;
    logic [36:0] rgot, rexp;
    logic [2:0]  egot;

    model_txn(e, trap);
    if (e < 0) begin
      checks++; failures++;
      $display("FAIL %s script: no completion within %0d cycles", name, MAXP);
      return;
    end
    exp_wr = trap ? 1'b0 : pat_wr[e];
    exp_rd = (trap || !pat_wr[e]) ? 32'h0 : pat_rd[e];

    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s req_ready_idle: got %b exp 1", name, bus.req_ready);
    end

    bus.req_valid = 1'b1;
    bus.req_insn  = insn;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_insn  = $urandom;
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;

    // ISSUE cycles: pcpi_valid high with stable payload, no response yet
    iexp = {1'b1, 1'b0, 1'b0, insn, rs1, rs2};
    for (int i = 0; i <= e; i++) begin
      igot = {bus.pcpi_valid, bus.rsp_valid, bus.req_ready, bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2};
      checks++;
      if (igot !== iexp) begin
        failures++;
        $display("FAIL %s issue_cycle%0d: got %h exp %h", name, i, igot, iexp);
      end
      bus.pcpi_wait  = pat_wait[i];
      bus.pcpi_ready = pat_ready[i];
      bus.pcpi_wr    = pat_wr[i];
      bus.pcpi_rd    = pat_rd[i];
      @(posedge clk);
      @(negedge clk);
    end

    // RESP: response present and held, PCPI inputs ignored
    rexp = {1'b0, 1'b1, 1'b0, exp_wr, trap, exp_rd};
    for (int d = 0; d <= rsp_delay; d++) begin
      rgot = {bus.pcpi_valid, bus.rsp_valid, bus.req_ready, bus.rsp_wr, bus.rsp_trap, bus.rsp_rd};
      checks++;
      if (rgot !== rexp) begin
        failures++;
        $display("FAIL %s resp_hold%0d: got %h exp %h", name, d, rgot, rexp);
      end
      bus.pcpi_wait  = 1'($urandom_range(1, 0));
      bus.pcpi_ready = 1'($urandom_range(1, 0));
      bus.pcpi_wr    = 1'($urandom_range(1, 0));
      bus.pcpi_rd    = $urandom;
      bus.rsp_ready  = (d == rsp_delay);
      @(posedge clk);
      @(negedge clk);
    end
    bus.rsp_ready  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wait  = 1'b0;

    egot = {bus.pcpi_valid, bus.rsp_valid, bus.req_ready};
    checks++;
    if (egot !== 3'b001) begin
      failures++;
      $display("FAIL %s after_handshake: got %b exp 001", name, egot);
    end
  endtask

  task automatic test_reset();
    logic [132:0] got;
    got = {bus.req_ready, bus.pcpi_valid, bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2,
           bus.rsp_valid, bus.rsp_wr, bus.rsp_rd, bus.rsp_trap};
    checks++;
    if (got !== {1'b1, 132'h0}) begin
      failures++;
      $display("FAIL reset_state: got %h exp %h", got, {1'b1, 132'h0});
    end
  endtask

  task automatic test_mul();
    clear_pat();
    pat_ready[2] = 1'b1;
    pat_wr[2]    = 1'b1;
    pat_rd[2]    = 32'd42;
    run_txn(32'h02B50533, 32'd7, 32'd6, 0, "mul");
  endtask

  task automatic test_timeout();
    clear_pat();
    pat_ready[40] = 1'b1;
    pat_wr[40]    = 1'b1;
    pat_rd[40]    = 32'h1234_5678;
    run_txn(32'h00000033, $urandom, $urandom, 1, "unclaimed");
  endtask

  task automatic test_wait_long();
    clear_pat();
    for (int i = 0; i < 40; i++) pat_wait[i] = 1'b1;
    pat_ready[40] = 1'b1;
    pat_wr[40]    = 1'b1;
    pat_rd[40]    = 32'hDEADBEEF;
    run_txn($urandom, $urandom, $urandom, 0, "wait_long");
  endtask

  task automatic test_ready_at_timeout();
    clear_pat();
    pat_ready[TO-1] = 1'b1;
    pat_wr[TO-1]    = 1'b1;
    pat_rd[TO-1]    = 32'h5;
    run_txn($urandom, $urandom, $urandom, 0, "ready_at_limit");
  endtask

  task automatic test_backpressure();
    clear_pat();
    pat_ready[1] = 1'b1;
    pat_wr[1]    = 1'b0;
    pat_rd[1]    = 32'hFFFF_FFFF;
    run_txn($urandom, $urandom, $urandom, 5, "backpressure_wr0");
    clear_pat();
    pat_ready[0] = 1'b1;
    pat_wr[0]    = 1'b1;
    pat_rd[0]    = 32'hA5A5_0F0F;
    run_txn($urandom, $urandom, $urandom, 5, "backpressure_wr1");
  endtask

  task automatic test_ignore_outside_issue();
    logic [2:0] got;
    for (int i = 0; i < 3; i++) begin
      bus.pcpi_ready = 1'b1;
      bus.pcpi_wait  = 1'b1;
      bus.pcpi_wr    = 1'b1;
      bus.pcpi_rd    = $urandom;
      @(posedge clk);
      @(negedge clk);
      got = {bus.pcpi_valid, bus.rsp_valid, bus.req_ready};
      checks++;
      if (got !== 3'b001) begin
        failures++;
        $display("FAIL idle_ignore%0d: got %b exp 001", i, got);
      end
    end
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wait  = 1'b0;
  endtask

  task automatic test_random();
    int len, dens;
    for (int n = 0; n < 30; n++) begin
      clear_pat();
      len  = int'($urandom_range(40, 0));
      dens = int'($urandom_range(3, 0));
      for (int i = 0; i < len; i++) pat_wait[i] = ($urandom_range(3, 0) < dens);
      pat_ready[len] = 1'b1;
      run_txn($urandom, $urandom, $urandom, int'($urandom_range(3, 0)), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_async_reset();
    logic [132:0] got;
    logic [2:0]   got2;
    bus.req_valid = 1'b1;
    bus.req_insn  = 32'h0000_0033;
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.pcpi_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_issue: got %b exp 1", bus.pcpi_valid);
    end
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    got = {bus.req_ready, bus.pcpi_valid, bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2,
           bus.rsp_valid, bus.rsp_wr, bus.rsp_rd, bus.rsp_trap};
    checks++;
    if (got !== {1'b1, 132'h0}) begin
      failures++;
      $display("FAIL rst_async: got %h exp %h", got, {1'b1, 132'h0});
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    got2 = {bus.pcpi_valid, bus.rsp_valid, bus.req_ready};
    checks++;
    if (got2 !== 3'b001) begin
      failures++;
      $display("FAIL rst_release: got %b exp 001", got2);
    end
    clear_pat();
    pat_ready[3] = 1'b1;
    pat_wr[3]    = 1'b1;
    run_txn($urandom, $urandom, $urandom, 1, "post_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_reset();

    test_mul();
    if (TO_EN) test_timeout();
    test_wait_long();
    test_ready_at_timeout();
    test_backpressure();
    test_ignore_outside_issue();
    test_random();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
